// File: rtl/fifo_drain_if.sv
// ----------------------------------------------------------------------------
// fifo_drain_if : FIFO read port plus valid/ready output stream of fifo_drain.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface fifo_drain_if #(
    parameter int WIDTH = 16
);
    logic             pop;
    logic             empty;
    logic             error;
    logic [WIDTH-1:0] data_out;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;

    modport master (
        output pop,
        output m_valid,
        output m_data,
        input  empty,
        input  error,
        input  data_out,
        input  m_ready
    );

    modport slave (
        input  pop,
        input  m_valid,
        input  m_data,
        output empty,
        output error,
        output data_out,
        output m_ready
    );
endinterface

`default_nettype wire

// File: rtl/fifo_drain.sv
// ----------------------------------------------------------------------------
// fifo_drain : pops a FIFO into a BUF_DEPTH-entry skid buffer feeding a stream.
// FIFO_DRAIN_ERRCNT_EN adds a saturating 8-bit FIFO error counter. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fifo_drain #(
    parameter int WIDTH     = 16,
    parameter int BUF_DEPTH = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    fifo_drain_if.master       bus,
    input  logic               drain_en,
    input  logic               flush,
`ifdef FIFO_DRAIN_ERRCNT_EN
    output logic [7:0]         err_cnt,
`endif
    output logic               busy
);

    localparam int c_occ_w = $clog2(BUF_DEPTH + 1);
    localparam int c_ptr_w = $clog2(BUF_DEPTH);
    localparam logic [c_occ_w:0]   c_depth    = (c_occ_w + 1)'(BUF_DEPTH);
    localparam logic [c_occ_w-1:0] c_occ_one  = c_occ_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(BUF_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_occ_w-1:0] r_occ;
    logic               r_inflight;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [WIDTH-1:0]   r_mem [BUF_DEPTH];
    logic [c_occ_w:0]   w_level;
    logic               w_pop;
    logic               w_m_valid;
    logic               w_capture;
    logic               w_xfer;

    function automatic logic [c_ptr_w-1:0] f_ptr_inc(input logic [c_ptr_w-1:0] p);
        return (p == c_ptr_last) ? '0 : p + c_ptr_one;
    endfunction

    // Words already buffered plus the one still in the FIFO read pipeline.
    assign w_level   = {1'b0, r_occ} + {{c_occ_w{1'b0}}, r_inflight};
    assign w_m_valid = (r_occ != '0);
    assign w_capture = r_inflight && !flush && (r_state != S_FLUSH);
    assign w_xfer    = w_m_valid && bus.m_ready && !flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (flush) begin
                    w_state_nxt = S_FLUSH;
                end else if (drain_en) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_pop = !bus.empty && !flush && (w_level < c_depth);
                if (flush) begin
                    w_state_nxt = S_FLUSH;
                end else if (!drain_en) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (!flush && !r_inflight) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_occ      <= '0;
            r_inflight <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_inflight <= w_pop;
            if (flush) begin
                // The read returning for an inflight pop is dropped along with the buffer.
                r_occ    <= '0;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_capture) begin
                    r_mem[r_wr_ptr] <= bus.data_out;
                    r_wr_ptr        <= f_ptr_inc(r_wr_ptr);
                end
                if (w_xfer) begin
                    r_rd_ptr <= f_ptr_inc(r_rd_ptr);
                end
                if (w_capture && !w_xfer) begin
                    r_occ <= r_occ + c_occ_one;
                end else if (!w_capture && w_xfer) begin
                    r_occ <= r_occ - c_occ_one;
                end
            end
        end
    end

    assign bus.pop     = w_pop;
    assign bus.m_valid = w_m_valid;
    assign bus.m_data  = r_mem[r_rd_ptr];
    assign busy        = (r_state != S_IDLE) || w_m_valid;

`ifdef FIFO_DRAIN_ERRCNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_cnt <= 8'd0;
        end else if (bus.error && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`else
    logic unused_error;
    assign unused_error = bus.error;
`endif

endmodule

`default_nettype wire

// File: doc/fifo_drain.md
FIFO_DRAIN -- requirements
Module: fifo_drain

Interface
REQ-001 Parameter WIDTH, default 16, data word width; equals the FIFO word width.
REQ-002 Parameter BUF_DEPTH, default 3, output skid-buffer entries; legal range 3..8.
REQ-003 clk  input  1  single clock; all state on posedge clk.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 drain_en  input  1  permits issuing pops to the FIFO.
REQ-006 flush  input  1  one-cycle pulse that discards buffered data.
REQ-007 empty  input  1  FIFO empty flag.
REQ-008 error  input  1  FIFO push/pop error flag.
REQ-009 data_out  input  WIDTH  FIFO read data, valid the cycle after a pop.
REQ-010 pop  output  1  pop request to the FIFO.
REQ-011 m_valid  output  1  output word available.
REQ-012 m_ready  input  1  sink accepts the word.
REQ-013 m_data  output  WIDTH  output word.
REQ-014 busy  output  1  high in any state other than IDLE, or while occupancy is nonzero.

Function
REQ-015 Pop is asserted only when all of these hold: state RUN, !empty, !flush, and occ + inflight < BUF_DEPTH.
- occ = number of words held in the buffer.
- inflight = pop registered last cycle.
REQ-016 The block never asserts pop while empty is high.
REQ-017 Read latency: data_out is captured into the buffer on the edge one cycle after the pop edge, then inflight clears.
REQ-018 Ordering is strictly FIFO; m_data is the oldest buffered word; a transfer occurs when m_valid && m_ready.
REQ-019 m_valid = (occ != 0).
- m_data and m_valid are stable while m_valid && !m_ready.
REQ-020 Throughput: sustains one word per cycle when empty is low and m_ready is high continuously.
REQ-021 A capture and a transfer in the same cycle leave occ unchanged; occ never exceeds BUF_DEPTH.
- occ is $clog2(BUF_DEPTH+1) bits.
- Buffer read and write pointers wrap modulo BUF_DEPTH.
REQ-022 FSM states and transitions:
- IDLE -> RUN when drain_en=1.
- RUN -> IDLE when drain_en=0; buffered words continue to drain.
- RUN or IDLE -> FLUSH on flush=1.
- FLUSH -> IDLE when inflight=0.
REQ-023 FLUSH behaviour:
- occ is set to 0 on the flush edge and m_valid drops the next cycle.
- The word arriving for an inflight pop is discarded, not buffered.
- pop stays low throughout FLUSH.
REQ-024 flush takes priority over drain_en and over a simultaneous m_ready transfer; the transfer does not occur.

Reset
REQ-025 While reset_n is low:
- state = IDLE; occ = 0; inflight = 0; pointers = 0.
- pop = 0; m_valid = 0; busy = 0; m_data = 0.
REQ-026 Reset takes effect asynchronously, including mid-pop; any inflight word is lost, and the FIFO side is reset by the same reset_n.
REQ-027 Deassertion is synchronous to clk.
- First pop no earlier than the second posedge after release, with drain_en high.

Configuration
REQ-028 Macro FIFO_DRAIN_ERRCNT_EN.
REQ-029 Defined:
- adds output err_cnt, 8 bits.
- err_cnt increments on each posedge where error=1.
- saturates at 255.
- cleared by reset only; flush does not clear it.
REQ-030 Undefined: err_cnt port absent, error input ignored, no counter logic; all other behaviour identical.

Verification
REQ-031 FIFO holds 5 words A..E, drain_en=1, m_ready=1 -> pop high for 5 consecutive cycles, m_data A..E on 5 consecutive cycles starting 2 cycles after the first pop, and pop never high with empty high.
REQ-032 FIFO holds 10 words, m_ready=0 -> exactly 3 pops, then pop low.
- m_valid high, m_data = first word, held stable.
- m_ready=1 -> remaining 7 words follow in order.
REQ-033 flush pulsed with occ=2 and inflight=1 -> m_valid low the next cycle, FLUSH lasts 1 cycle, no captured word is delivered, and the next delivered word is the FIFO's next entry.
REQ-034 reset_n dropped mid-stream between clocks -> pop, m_valid and busy go low immediately, without waiting for an edge.
- Restart after release delivers the post-reset FIFO contents only.
REQ-035 ERRCNT_EN defined, error held high for 300 cycles -> err_cnt = 255, no wrap.
- Macro undefined -> build has no err_cnt port.
REQ-036 Single word in FIFO with drain_en toggling 1->0 on the pop cycle -> that word is still delivered once and the FSM ends in IDLE.
